instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  Fetch stage feeding the combinational program ROM and the decode logic.
//  - Owns the PC and drives the ROM address.
//  - Captures the returned instruction in an output register, with a valid/ready handshake to decode.
//  - Accepts branch/jump redirects from execute and stops fetching at EBREAK.
// PARAMETERS
//  DATA_WIDTH    32            instruction/address width
//  RESET_PC      32'h0040_0000 PC after reset (text base; ROM index 0)
//  MEMORY_DEPTH  32            ROM depth in words; used only by the bound check
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low reset
//  Address_o      out  32  ROM address; equals pc_q combinationally
//  Instruction_i  in   32  ROM data; valid in the same cycle as Address_o
//  Ready_i        in   1   decode accepts Instr_o this cycle
//  Valid_o        out  1   Instr_o/PC_o hold a valid fetched instruction
//  Instr_o        out  32  fetched instruction
//  PC_o           out  32  address of Instr_o
//  Redirect_i     in   1   execute resolved a taken branch/jump
//  Target_i       in   32  redirect target PC
//  Halted_o       out  1   fetch stopped after an EBREAK
//  Fault_o        out  1   bound/misalign fault (FETCH_BOUND_CHECK_EN only; else 0)
// BEHAVIOUR
//  Reset (async, reset==0):
//   - pc_q=RESET_PC, state=START, Valid_o=0, Instr_o=32'h0000_0013 (NOP), PC_o=0, Halted_o=0, Fault_o=0.
//  States:
//   - START: 1 cycle, no fetch; unconditionally go to RUN.
//   - RUN: normal fetching.
//   - HALT: no fetch; Halted_o=1.
//   - FAULT: no fetch; Fault_o=1.
//  Handshake:
//   - Transfer when Valid_o&&Ready_i.
//   - Once Valid_o=1, Instr_o and PC_o stay stable until transfer.
//  Fetch fire (RUN, !Redirect_i, (!Valid_o||Ready_i)):
//   - Instr_o<=Instruction_i, PC_o<=pc_q, Valid_o<=1, pc_q<=pc_q+4 (wraps mod 2^32).
//   - Latency: address presented at cycle N -> Valid_o at N+1. Throughput is 1 per cycle while Ready_i=1.
//  Stall (Valid_o&&!Ready_i): pc_q and the output register hold.
//  Redirect_i=1 (any state except START; highest priority, even over a stall):
//   - Valid_o<=0 (flush; a same-cycle transfer still counts as accepted).
//   - pc_q<=Target_i; state<=RUN (exits HALT).
//   - Fetch resumes the next cycle, so the first target instruction appears 2 cycles after the redirect.
//   - Without FETCH_BOUND_CHECK_EN, Target_i[1:0] is forced to 2'b00.
//  EBREAK (32'h0010_0073) captured on a fire:
//   - It is delivered normally (Valid_o=1).
//   - state<=HALT and Halted_o=1 from the next cycle.
//   - A redirect in the same cycle wins over the halt.
//  Reset asserted mid-operation: all state returns to reset values immediately; any in-flight instruction is discarded.
// CONFIGURATION
//  FETCH_BOUND_CHECK_EN defined:
//   - Fault when ((pc_q-RESET_PC)>>2)>=MEMORY_DEPTH at a would-be fire, or when a redirect has Target_i[1:0]!=0.
//   - On fault: no fire, state<=FAULT, Fault_o=1, PC_o<=faulting address, Valid_o<=0.
//   - Only reset or a well-formed redirect leaves FAULT.
//  FETCH_BOUND_CHECK_EN undefined:
//   - No check; Fault_o is tied to 0; FAULT state is unreachable.
// STRUCTURE
//  Package fetch_pkg: state enum (START,RUN,HALT,FAULT), NOP_INSTR, EBREAK_INSTR, PC_STEP=4.
//  Sub-module fetch_pc_reg: PC register with async active-low reset to RESET_PC and load/increment/hold select.
//  The FSM and output register stay in the top module.
// TESTING
//  1. Reset, Ready_i=1, ROM holds 0x00500093.. -> Address_o 0x400000 at START; Valid_o=1, PC_o=0x400000 two cycles after reset release; then +4 each cycle.
//  2. Hold Ready_i=0 for 3 cycles while Valid_o=1 -> Instr_o/PC_o/Address_o stable; Ready_i=1 resumes with no duplicate or skipped PC.
//  3. Redirect_i=1, Target_i=0x400040 during a stall -> Valid_o=0 next cycle; then PC_o=0x400040 with Valid_o=1.
//  4. ROM word 3 = 0x00100073 -> EBREAK delivered at PC 0x40000C; Halted_o=1 and Address_o frozen; a later redirect restarts fetch.
//  5. With FETCH_BOUND_CHECK_EN: Target_i=0x400002 -> Fault_o=1, PC_o=0x400002; run past word 31 -> Fault_o=1 at 0x400080.
//  6. Assert reset mid-run with Valid_o=1 -> Valid_o=0, Address_o=0x400000 asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch control states. FAULT is only reachable with FETCH_BOUND_CHECK_EN.
  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] PC_STEP      = 32'd4;

  function automatic logic is_ebreak(input logic [31:0] instr);
    return instr == EBREAK_INSTR;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load, increment by PC_STEP, or hold.
// Latency: new PC visible one cycle after load/inc.
// Backpressure: none; the caller holds by deasserting both load and inc.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, PC returns to RESET_PC
//   load     take load_pc (wins over inc)
//   load_pc  value to load
//   inc      advance PC by PC_STEP (wraps mod 2^DATA_WIDTH)
//   pc_q     current PC
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] pc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc;
    end else if (inc) begin
      pc_q <= pc_q + DATA_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: drives ROM address from the PC, registers the returned word for decode.
// Latency: address presented in cycle N -> Valid_o in N+1; redirect -> target instruction 2 cycles later.
// Backpressure: Valid_o/Ready_i handshake; with Valid_o && !Ready_i the PC and output register hold.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   Address_o / Instruction_i  combinational ROM interface (Address_o == pc_q)
//   Valid_o, Ready_i           handshake to decode for Instr_o / PC_o
//   Redirect_i, Target_i       taken branch/jump from execute
//   Halted_o                   fetch stopped after delivering an EBREAK
//   Fault_o                    bound/misalign fault
//
// Build option FETCH_BOUND_CHECK_EN: when defined, fetches beyond MEMORY_DEPTH words
// and misaligned redirect targets raise Fault_o. When undefined, Fault_o stays 0 and
// redirect targets are word-aligned by clearing Target_i[1:0].
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Ready_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Target_i,
  output logic                  Halted_o,
  output logic                  Fault_o
);

  fetch_state_t          state_q;
  logic [DATA_WIDTH-1:0] pc_q;

  logic                  redirect_take;
  logic                  would_fire;
  logic                  fire;
  logic                  bound_fault;
  logic                  target_misaligned;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  pc_load;

  // Redirects arriving during the single START cycle are ignored.
  assign redirect_take = Redirect_i && (state_q != START);

  // A fetch may go ahead when running, not being redirected, and the output
  // register is either empty or being drained this cycle.
  assign would_fire = (state_q == RUN) && !Redirect_i && (!Valid_o || Ready_i);

`ifdef FETCH_BOUND_CHECK_EN
  // Byte-offset compare is equivalent to ((pc-base)>>2) >= depth; a PC below
  // the base wraps to a huge offset and faults too.
  localparam logic [DATA_WIDTH-1:0] BOUND_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);
  logic [DATA_WIDTH-1:0] pc_offset;

  assign pc_offset         = pc_q - RESET_PC;
  assign bound_fault       = pc_offset >= BOUND_BYTES;
  assign target_misaligned = Target_i[1:0] != 2'b00;
  assign redirect_target   = Target_i;
`else
  // Depth and the low target bits only matter when the bound check is built in.
  logic [DATA_WIDTH+1:0] cfg_unused;

  assign cfg_unused        = {DATA_WIDTH'(MEMORY_DEPTH), Target_i[1:0]};
  assign bound_fault       = 1'b0;
  assign target_misaligned = 1'b0;
  assign redirect_target   = {Target_i[DATA_WIDTH-1:2], 2'b00};
`endif

  assign fire    = would_fire && !bound_fault;
  // A misaligned target faults instead of loading, leaving the PC untouched.
  assign pc_load = redirect_take && !target_misaligned;

  fetch_pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (reset),
    .load    (pc_load),
    .load_pc (redirect_target),
    .inc     (fire),
    .pc_q    (pc_q)
  );

  assign Address_o = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= START;
      Valid_o  <= 1'b0;
      Instr_o  <= DATA_WIDTH'(NOP_INSTR);
      PC_o     <= '0;
      Halted_o <= 1'b0;
      Fault_o  <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          state_q <= RUN;
        end
        default: begin
          // Decode took the current word; may be overridden by a new fetch below.
          if (Valid_o && Ready_i) begin
            Valid_o <= 1'b0;
          end

          if (redirect_take) begin
            // Flush wins over stall, halt and fault.
            Valid_o <= 1'b0;
            if (target_misaligned) begin
              state_q  <= FAULT;
              Fault_o  <= 1'b1;
              Halted_o <= 1'b0;
              PC_o     <= Target_i;
            end else begin
              state_q  <= RUN;
              Fault_o  <= 1'b0;
              Halted_o <= 1'b0;
            end
          end else if (would_fire && bound_fault) begin
            state_q <= FAULT;
            Fault_o <= 1'b1;
            PC_o    <= pc_q;
            Valid_o <= 1'b0;
          end else if (fire) begin
            Instr_o <= Instruction_i;
            PC_o    <= pc_q;
            Valid_o <= 1'b1;
            // The EBREAK itself is still delivered; only further fetches stop.
            if (is_ebreak(32'(Instruction_i))) begin
              state_q  <= HALT;
              Halted_o <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
